hamming74_frame_encoder: RTL and testbench



---
 rtl/hamming74_pkg.sv | 27 ++
 rtl/hamming74_nibble_enc.sv | 20 ++
 rtl/hamming74_frame_encoder.sv | 125 ++++++++++++
 tb/tb_hamming74_frame_encoder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming74_pkg.sv
// Shared constants, types and codeword bit positions for the Hamming(7,4) frame encoder.
package hamming74_pkg;

    localparam int DATA_W  = 32;
    localparam int FRAME_W = 64;
    localparam int CW_W    = 7;
    localparam int NIBBLES = 8;
    localparam int PAD_W   = 8;

    typedef logic [FRAME_W-1:0] frame_t;
    typedef logic [DATA_W-1:0]  word_t;

    // Codeword bit positions: parity bits at 0, 1 and 3, data bits d0..d3 at 2, 4, 5, 6
    localparam int CW_P0 = 0;
    localparam int CW_P1 = 1;
    localparam int CW_D0 = 2;
    localparam int CW_P2 = 3;
    localparam int CW_D1 = 4;
    localparam int CW_D2 = 5;
    localparam int CW_D3 = 6;

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_t;

endpackage

// File: rtl/hamming74_nibble_enc.sv
// Combinational Hamming(7,4) encoder for one nibble.
module hamming74_nibble_enc
    import hamming74_pkg::*;
(
    input  logic [3:0]      i_nibble,
    output logic [CW_W-1:0] o_cw
);

    always_comb begin
        o_cw        = '0;
        o_cw[CW_P0] = i_nibble[0] ^ i_nibble[1] ^ i_nibble[3];
        o_cw[CW_P1] = i_nibble[0] ^ i_nibble[2] ^ i_nibble[3];
        o_cw[CW_D0] = i_nibble[0];
        o_cw[CW_P2] = i_nibble[1] ^ i_nibble[2] ^ i_nibble[3];
        o_cw[CW_D1] = i_nibble[1];
        o_cw[CW_D2] = i_nibble[2];
        o_cw[CW_D3] = i_nibble[3];
    end

endmodule

// File: rtl/hamming74_frame_encoder.sv
// Serial 32-bit payload collector and double-buffered Hamming(7,4) 64-bit frame serialiser.
// Optional macro HAMMING_ENC_FRAME_TAG_EN puts an 8-bit frame sequence number in the pad byte.
module hamming74_frame_encoder
    import hamming74_pkg::*;
(
    input  logic clk_encoder,
    input  logic rst_n,
    input  logic enc_in_valid,
    input  logic enc_in_data,
    output logic enc_in_ready,
    output logic enc_out_valid,
    output logic enc_out_data,
    input  logic enc_out_ready,
    output logic enc_frame_done
);

    logic [4:0]        r_in_cnt;
    word_t             r_in_buf;
    word_t             r_hold_buf;
    logic              r_hold_full;
    tx_state_t         r_state;
    tx_state_t         w_state_nxt;
    logic [5:0]        r_tx_cnt;
    frame_t            r_tx_shift;
    logic              r_frame_done;

    word_t             w_word;
    frame_t            w_frame;
    logic [PAD_W-1:0]  w_pad;
    logic              w_in_acc;
    logic              w_in_last;
    logic              w_xfer;
    logic              w_tx_last;
    logic              w_load;

    assign w_in_last    = (r_in_cnt == 5'd31);
    assign enc_in_ready = !(r_hold_full && w_in_last);
    assign w_in_acc     = enc_in_valid && enc_in_ready;
    assign w_xfer       = (r_state == TX_SHIFT) && enc_out_ready;
    assign w_tx_last    = w_xfer && (r_tx_cnt == 6'd63);
    // A frame loads from IDLE, or on the last transfer so back-to-back frames have no gap
    assign w_load       = r_hold_full && ((r_state == TX_IDLE) || w_tx_last);

    always_comb begin
        w_word                   = r_in_buf;
        w_word[5'd31 - r_in_cnt] = enc_in_data;
    end

    always_ff @(posedge clk_encoder) begin
        if (!rst_n) begin
            r_in_cnt    <= '0;
            r_in_buf    <= '0;
            r_hold_buf  <= '0;
            r_hold_full <= 1'b0;
        end else begin
            if (w_in_acc) begin
                r_in_buf <= w_word;
                r_in_cnt <= r_in_cnt + 5'd1;
                if (w_in_last) begin
                    r_hold_buf <= w_word;
                end
            end
            if (w_in_acc && w_in_last) begin
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NIBBLES; k++) begin : g_cw
        hamming74_nibble_enc u_nibble_enc (
            .i_nibble (r_hold_buf[4*k +: 4]),
            .o_cw     (w_frame[CW_W*k +: CW_W])
        );
    end
    assign w_frame[FRAME_W-1 -: PAD_W] = w_pad;

`ifdef HAMMING_ENC_FRAME_TAG_EN
    logic [PAD_W-1:0] r_tag;

    always_ff @(posedge clk_encoder) begin
        if (!rst_n) begin
            r_tag <= '0;
        end else if (w_load) begin
            r_tag <= r_tag + PAD_W'(1);
        end
    end
    assign w_pad = r_tag;
`else
    assign w_pad = '0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            TX_IDLE:  if (r_hold_full) w_state_nxt = TX_SHIFT;
            TX_SHIFT: if (w_tx_last && !r_hold_full) w_state_nxt = TX_IDLE;
            default:  w_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_encoder) begin
        if (!rst_n) begin
            r_state      <= TX_IDLE;
            r_tx_cnt     <= '0;
            r_tx_shift   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_tx_last;
            if (w_load) begin
                r_tx_shift <= w_frame;
                r_tx_cnt   <= '0;
            end else if (w_xfer) begin
                r_tx_cnt <= r_tx_cnt + 6'd1;
            end
        end
    end

    assign enc_out_valid  = (r_state == TX_SHIFT);
    assign enc_out_data   = r_tx_shift[6'd63 - r_tx_cnt];
    assign enc_frame_done = r_frame_done;

endmodule

// File: tb/tb_hamming74_frame_encoder.sv
// Directed bench for hamming74_frame_encoder: frame contents, latency, streaming, stalls, reset, pad tag.
module tb_hamming74_frame_encoder;

`ifdef HAMMING_ENC_FRAME_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    logic clk_encoder = 1'b0;
    logic rst_n       = 1'b0;
    logic enc_in_valid = 1'b0;
    logic enc_in_data  = 1'b0;
    logic enc_in_ready;
    logic enc_out_valid;
    logic enc_out_data;
    logic enc_out_ready = 1'b1;
    logic enc_frame_done;

    int   checks   = 0;
    int   failures = 0;
    bit   rdyMode  = 1'b0;
    bit   rxBits[$];
    int   doneCount    = 0;
    int   bitsAccepted = 0;
    int   inStalls     = 0;
    int   badDrops     = 0;
    int   unstable     = 0;
    bit   prevStall    = 1'b0;
    logic prevData     = 1'b0;

    hamming74_frame_encoder dut (
        .clk_encoder    (clk_encoder),
        .rst_n          (rst_n),
        .enc_in_valid   (enc_in_valid),
        .enc_in_data    (enc_in_data),
        .enc_in_ready   (enc_in_ready),
        .enc_out_valid  (enc_out_valid),
        .enc_out_data   (enc_out_data),
        .enc_out_ready  (enc_out_ready),
        .enc_frame_done (enc_frame_done)
    );

    always #5 clk_encoder = ~clk_encoder;

    // Inputs change #1 after the rising edge; the monitor samples on the falling edge
    initial forever begin
        @(posedge clk_encoder);
        #1;
        enc_out_ready = rdyMode ? ($urandom_range(0, 9) < 7) : 1'b1;
    end

    always @(negedge clk_encoder) begin
        if (enc_out_valid && enc_out_ready) rxBits.push_back(enc_out_data);
        if (enc_frame_done) doneCount++;
        if (!enc_in_ready && (bitsAccepted % 32) != 31) badDrops++;
        if (enc_in_valid && !enc_in_ready) inStalls++;
        if (enc_in_valid && enc_in_ready) bitsAccepted++;
        if (prevStall && enc_out_valid && enc_out_data !== prevData) unstable++;
        prevStall = enc_out_valid && !enc_out_ready;
        prevData  = enc_out_data;
    end

    function automatic logic [7:0] padOf(input int n);
        logic [31:0] v;
        v = n;
        return TAG_EN ? v[7:0] : 8'h00;
    endfunction

    function automatic logic [63:0] golden(input logic [31:0] w, input int n);
        logic [63:0] f;
        logic [3:0]  d;
        f = '0;
        for (int k = 0; k < 8; k++) begin
            d = w[4*k +: 4];
            f[7*k +: 7] = {d[3], d[2], d[1], d[1]^d[2]^d[3], d[0], d[0]^d[2]^d[3], d[0]^d[1]^d[3]};
        end
        f[63:56] = padOf(n);
        return f;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic resetDut();
        rst_n        = 1'b0;
        enc_in_valid = 1'b0;
        repeat (2) @(posedge clk_encoder);
        #1;
        rxBits.delete();
        doneCount    = 0;
        bitsAccepted = 0;
        inStalls     = 0;
        badDrops     = 0;
        unstable     = 0;
        rst_n        = 1'b1;
        @(posedge clk_encoder);
        #1;
    endtask

    // Sends one payload word MSB first, honouring enc_in_ready
    task automatic applyStimulus(input logic [31:0] word);
        int  guard;
        bit  done;
        for (int i = 31; i >= 0; i--) begin
            guard = 0;
            done  = 1'b0;
            enc_in_valid = 1'b1;
            enc_in_data  = word[i];
            while (!done) begin
                @(negedge clk_encoder);
                if (enc_in_ready) done = 1'b1;
                @(posedge clk_encoder);
                #1;
                if (!done) begin
                    guard++;
                    if (guard > 200) begin
                        checkOutput("inReadyTimeout", 64'd0, 64'd1);
                        enc_in_valid = 1'b0;
                        return;
                    end
                end
            end
        end
        enc_in_valid = 1'b0;
    endtask

    task automatic checkFrame(input string tag, input logic [63:0] exp);
        int          guard;
        logic [63:0] got;
        guard = 0;
        while (rxBits.size() < 64 && guard < 3000) begin
            @(negedge clk_encoder);
            guard++;
        end
        if (rxBits.size() < 64) begin
            checkOutput({tag, "Timeout"}, 64'(rxBits.size()), 64'd64);
            return;
        end
        got = '0;
        for (int b = 0; b < 64; b++) got = {got[62:0], rxBits.pop_front()};
        checkOutput(tag, got, exp);
    endtask

    initial begin
        int guard;
        int runLen;

        $display("[TB] start, tag feature %0d", TAG_EN);
        rst_n = 1'b0;
        @(posedge clk_encoder);
        #1;
        @(negedge clk_encoder);
        checkOutput("rstInReady", 64'(enc_in_ready), 64'd1);
        checkOutput("rstOutValid", 64'(enc_out_valid), 64'd0);
        checkOutput("rstOutData", 64'(enc_out_data), 64'd0);
        checkOutput("rstFrameDone", 64'(enc_frame_done), 64'd0);
        resetDut();

        applyStimulus(32'h0000_000F);
        @(negedge clk_encoder);
        checkOutput("latE0Valid", 64'(enc_out_valid), 64'd0);
        @(negedge clk_encoder);
        checkOutput("latE1Valid", 64'(enc_out_valid), 64'd1);
        checkFrame("frame0F", 64'h0000_0000_0000_007F | (64'(padOf(0)) << 56));
        repeat (3) @(negedge clk_encoder);
        checkOutput("doneOnce", 64'(doneCount), 64'd1);
        checkOutput("idleAfter", 64'(enc_out_valid), 64'd0);

        @(posedge clk_encoder);
        #1;
        applyStimulus(32'h1000_0000);
        checkFrame("frame1000", 64'h000E_0000_0000_0000 | (64'(padOf(1)) << 56));
        applyStimulus(32'hFFFF_FFFF);
        checkFrame("frameFFFF", 64'h00FF_FFFF_FFFF_FFFF | (64'(padOf(2)) << 56));

        resetDut();
        runLen = 0;
        fork
            begin
                applyStimulus(32'h1234_5678);
                applyStimulus(32'hA5A5_A5A5);
                applyStimulus(32'h0F0F_0F0F);
            end
            begin
                guard = 0;
                while (!enc_out_valid && guard < 2000) begin
                    @(negedge clk_encoder);
                    guard++;
                end
                while (enc_out_valid && runLen < 1000) begin
                    runLen++;
                    @(negedge clk_encoder);
                end
            end
        join
        checkOutput("streamRun", 64'(runLen), 64'd192);
        checkOutput("streamInStalls", 64'(inStalls), 64'd2);
        checkOutput("streamBadDrops", 64'(badDrops), 64'd0);
        checkFrame("stream0", golden(32'h1234_5678, 0));
        checkFrame("stream1", golden(32'hA5A5_A5A5, 1));
        checkFrame("stream2", golden(32'h0F0F_0F0F, 2));

        @(posedge clk_encoder);
        #1;
        rdyMode = 1'b1;
        unstable = 0;
        applyStimulus(32'hDEAD_BEEF);
        checkFrame("stallFrame", golden(32'hDEAD_BEEF, 3));
        rdyMode = 1'b0;
        checkOutput("stallStable", 64'(unstable), 64'd0);

        @(posedge clk_encoder);
        #1;
        applyStimulus(32'hCAFE_F00D);
        guard = 0;
        while (rxBits.size() < 20 && guard < 500) begin
            @(posedge clk_encoder);
            #1;
            guard++;
        end
        checkOutput("midFrameReach", 64'(rxBits.size() >= 20), 64'd1);
        rst_n = 1'b0;
        @(posedge clk_encoder);
        @(negedge clk_encoder);
        checkOutput("midRstInReady", 64'(enc_in_ready), 64'd1);
        checkOutput("midRstOutValid", 64'(enc_out_valid), 64'd0);
        checkOutput("midRstOutData", 64'(enc_out_data), 64'd0);
        checkOutput("midRstDone", 64'(enc_frame_done), 64'd0);
        resetDut();
        applyStimulus(32'h1357_9BDF);
        checkFrame("postRstFrame", golden(32'h1357_9BDF, 0));

        resetDut();
        applyStimulus(32'h0000_0001);
        applyStimulus(32'h8000_0000);
        applyStimulus(32'h5555_AAAA);
        applyStimulus(32'h0000_0000);
        checkFrame("tagFrame0", golden(32'h0000_0001, 0));
        checkFrame("tagFrame1", golden(32'h8000_0000, 1));
        checkFrame("tagFrame2", golden(32'h5555_AAAA, 2));
        checkFrame("tagFrame3", golden(32'h0000_0000, 3));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
